win_line_scheduler: RTL and testbench

- Sequences the five-in-a-row win check after each stone is placed on the 16x16 board.
- Scans four directions through the placed cell in turn: horizontal, vertical, diagonal and anti-diagonal.
- Owns the single board read port for the whole scan and reports win/no-win to the game FSM.
- Sits between the move pointer/placement logic and the board memory, and replaces per-direction checker instances.

---
 rtl/win_line_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_win_line_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/win_line_scheduler.sv
// win_line_scheduler: sequences the five-in-a-row check through a newly placed
// stone. Scans H, V, D and A in turn over one synchronous board read port,
// counting consecutive same-colour cells one cycle behind the read.
module win_line_scheduler #(
    parameter int unsigned RUN_LEN = 5,
    parameter int unsigned SPAN    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] pos_x,
    input  logic [3:0] pos_y,
    input  logic [1:0] player,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [1:0] win_dir
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic signed [5:0] K_LAST  = 6'(SPAN);
    localparam logic signed [5:0] K_FIRST = -K_LAST;
    localparam logic [2:0]        RUN_MAX = 3'(RUN_LEN);
    localparam logic [2:0]        RUN_HIT = 3'(RUN_LEN - 1);

    state_t            r_state;
    state_t            w_next;

    logic [3:0]        r_px;
    logic [3:0]        r_py;
    logic [1:0]        r_player;
    logic [1:0]        r_dir;
    logic signed [5:0] r_k;
    logic [2:0]        r_run;
    logic              r_cmp_valid;
    logic              r_cmp_on;
    logic [7:0]        r_last_addr;
    logic              r_win;
    logic [1:0]        r_win_dir;

    logic signed [5:0] w_bx;
    logic signed [5:0] w_by;
    logic signed [5:0] w_tx;
    logic signed [5:0] w_ty;
    logic              w_on;
    logic              w_match;
    logic              w_hit;
    logic              w_accept;

    assign w_bx = {2'b00, r_px};
    assign w_by = {2'b00, r_py};

    // Target cell for the current offset along the current direction.
    always_comb begin
        w_tx = w_bx;
        w_ty = w_by;
        unique case (r_dir)
            2'd0: w_tx = w_bx + r_k;
            2'd1: w_ty = w_by + r_k;
            2'd2: begin
                w_tx = w_bx + r_k;
                w_ty = w_by + r_k;
            end
            default: begin
                w_tx = w_bx + r_k;
                w_ty = w_by - r_k;
            end
        endcase
    end

    // Both coordinates in 0..15 means the upper two bits are clear.
    assign w_on     = (w_tx[5:4] == 2'b00) && (w_ty[5:4] == 2'b00);
    assign w_match  = r_cmp_valid && r_cmp_on && (rd_data == r_player);
    // Win is decided combinationally so the read issued in the same cycle is suppressed.
    assign w_hit    = w_match && (r_run >= RUN_HIT);
    assign w_accept = (r_state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and strobes.
    always_comb begin
        w_next = r_state;
        rd_en  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (player == 2'b00) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (w_hit) begin
                    w_next = DONE;
                end else begin
                    rd_en = w_on;
                    if (r_k == K_LAST) begin
                        w_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_hit || (r_dir == 2'd3)) begin
                    w_next = DONE;
                end else begin
                    w_next = SCAN;
                end
            end
            default: begin
                done   = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    assign rd_addr = rd_en ? {w_ty[3:0], w_tx[3:0]} : r_last_addr;
    assign win     = r_win;
    assign win_dir = r_win_dir;

    // Request latch, offset/direction counters, compare pipeline and result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_px        <= '0;
            r_py        <= '0;
            r_player    <= '0;
            r_dir       <= '0;
            r_k         <= K_FIRST;
            r_run       <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_on    <= 1'b0;
            r_last_addr <= '0;
            r_win       <= 1'b0;
            r_win_dir   <= '0;
        end else begin
            r_cmp_valid <= (r_state == SCAN) && !w_hit;
            r_cmp_on    <= w_on;

            if (rd_en) begin
                r_last_addr <= rd_addr;
            end

            if ((r_state == SCAN) && !w_hit) begin
                r_k <= (r_k == K_LAST) ? K_FIRST : r_k + 6'sd1;
            end

            if (r_cmp_valid) begin
                if (w_match) begin
                    if (r_run < RUN_MAX) begin
                        r_run <= r_run + 3'd1;
                    end
                end else begin
                    r_run <= '0;
                end
            end

            if (w_hit) begin
                r_win     <= 1'b1;
                r_win_dir <= r_dir;
            end

            // Direction change overrides the DRAIN compare update of run.
            if ((r_state == DRAIN) && !w_hit && (r_dir != 2'd3)) begin
                r_dir <= r_dir + 2'd1;
                r_run <= '0;
            end

            if (w_accept) begin
                r_px        <= pos_x;
                r_py        <= pos_y;
                r_player    <= player;
                r_dir       <= '0;
                r_k         <= K_FIRST;
                r_run       <= '0;
                r_win       <= 1'b0;
                r_win_dir   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_win_line_scheduler.sv
// tb_win_line_scheduler: directed vectors against a synchronous board model.
// Stimulus pushes expected results into a scoreboard; a negedge monitor pops
// and compares on each done pulse and on each read (for address-checked runs).
module tb_win_line_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pos_x = '0;
    logic [3:0] pos_y = '0;
    logic [1:0] player = '0;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [1:0] rd_data = '0;
    logic       busy;
    logic       done;
    logic       win;
    logic [1:0] win_dir;

    win_line_scheduler #(.RUN_LEN(5), .SPAN(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .pos_x(pos_x), .pos_y(pos_y), .player(player),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .win(win), .win_dir(win_dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       win;
        logic [1:0] dir;
        int         lat;
        int         reads;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] addr_q[$];
    logic [1:0] mem[256];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0_cyc   = 0;
    int n_done   = 0;
    int rd_cnt   = 0;
    logic busy_chk = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read board memory.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] a;
        if (reset) begin
            rd_cnt   = 0;
            busy_chk = 1'b0;
        end else begin
            if (busy_chk) begin
                chk("busy_after_done", int'(busy), 0);
                busy_chk = 1'b0;
            end
            if (rd_en) begin
                rd_cnt++;
                if (addr_q.size() > 0) begin
                    a = addr_q.pop_front();
                    chk("rd_addr", int'(rd_addr), int'(a));
                end
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("win", int'(win), int'(e.win));
                    chk("win_dir", int'(win_dir), int'(e.dir));
                    chk("done_latency", cyc - t0_cyc + 1, e.lat);
                    chk("read_count", rd_cnt, e.reads);
                end
                rd_cnt = 0;
                n_done++;
                busy_chk = 1'b1;
            end
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 256; i++) mem[i] = 2'b00;
    endtask

    task automatic put(input int x, input int y, input logic [1:0] c);
        mem[y*16 + x] = c;
    endtask

    task automatic issue(input int x, input int y, input logic [1:0] pl,
                         input logic ew, input logic [1:0] ed, input int el,
                         input int er, input bit push);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.win = ew; e.dir = ed; e.lat = el; e.reads = er;
            sb_q.push_back(e);
        end
        pos_x  = 4'(x);
        pos_y  = 4'(y);
        player = pl;
        start  = 1'b1;
        @(posedge clk);
        #1;
        t0_cyc = cyc;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int n0, input string name);
        for (int c = 0; c < 200 && n_done == n0; c++) @(negedge clk);
        if (n_done == n0) chk({name, "_timeout"}, 0, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int x, input int y, input logic [1:0] pl,
                       input logic ew, input logic [1:0] ed, input int el,
                       input int er, input string name);
        int n0;
        n0 = n_done;
        issue(x, y, pl, ew, ed, el, er, 1'b1);
        wait_done(n0, name);
    endtask

    task automatic board_anti();
        clear_board();
        put(2, 9, 2'b11); put(3, 8, 2'b11); put(4, 7, 2'b11);
        put(5, 6, 2'b11); put(6, 5, 2'b11);
    endtask

    task automatic board_broken();
        clear_board();
        for (int x = 0; x <= 8; x++) put(x, 0, 2'b01);
        put(4, 0, 2'b10);
    endtask

    initial begin
        int n0;
        int pulses[4] = '{3, 20, 40, 41};
        clear_board();
        repeat (3) @(negedge clk);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_win", int'(win), 0);
        chk("reset_win_dir", int'(win_dir), 0);
        #1 reset = 1'b0;

        // Horizontal win, with exact read addresses.
        clear_board();
        for (int x = 3; x <= 7; x++) put(x, 7, 2'b01);
        for (int x = 1; x <= 7; x++) addr_q.push_back(8'(8'h70 + x));
        run(5, 7, 2'b01, 1'b1, 2'd0, 9, 7, "horiz");
        chk("addr_q_drained", addr_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("win_held", int'(win), 1);

        // Vertical at the corner: off-board offsets issue no reads.
        clear_board();
        for (int y = 0; y <= 4; y++) put(0, y, 2'b10);
        run(0, 0, 2'b10, 1'b1, 2'd1, 21, 10, "vert_edge");

        // Anti-diagonal after three full directions.
        board_anti();
        run(4, 7, 2'b11, 1'b1, 2'd3, 39, 34, "anti");

        // Reset during V scan: outputs drop at once, no done pulse.
        issue(4, 7, 2'b11, 1'b0, 2'd0, 0, 0, 1'b0);
        while (cyc < t0_cyc + 14) @(negedge clk);
        chk("mid_rd_en_before", int'(rd_en), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd_en", int'(rd_en), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_win", int'(win), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        run(4, 7, 2'b11, 1'b1, 2'd3, 39, 34, "anti_after_reset");

        // Broken run: full scan, no win.
        board_broken();
        run(3, 0, 2'b01, 1'b0, 2'd0, 41, 22, "broken");

        // Six in a row wins on the fifth match.
        clear_board();
        for (int x = 0; x <= 5; x++) put(x, 0, 2'b01);
        run(3, 0, 2'b01, 1'b1, 2'd0, 8, 5, "six_row");

        // Empty player: immediate done, clears the previous win.
        run(9, 9, 2'b00, 1'b0, 2'd0, 1, 0, "empty_player");

        // Start pulses while busy are ignored: exactly one done.
        board_broken();
        n0 = n_done;
        issue(3, 0, 2'b01, 1'b0, 2'd0, 41, 22, 1'b1);
        foreach (pulses[p]) begin
            while (cyc < t0_cyc + pulses[p] - 1) @(negedge clk);
            pos_x = 4'd0; pos_y = 4'd0; player = 2'b10;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int c = 0; c < 200 && n_done == n0; c++) @(negedge clk);
        if (n_done == n0) chk("ignored_start_timeout", 0, 1);
        repeat (20) @(negedge clk);
        chk("single_done", n_done - n0, 1);
        chk("idle_after_ignored", int'(busy), 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
